// File: rtl/crypto_pkg.sv
// ---------------------------------------------------------------------------
// crypto_pkg
// Shared definitions for the crypto pipeline datapath blocks.
//   CRYPTO_WIDTH  : default operand width (255 bits)
//   P25519        : 2^255 - 19, the default prime modulus
//   aff_state_t   : state encoding of the proj_to_affine controller
//   popcount()    : constant function, number of set bits in a vector
//   aff_latency() : accept-to-result latency of proj_to_affine for a given
//                   width and exponent popcount
// ---------------------------------------------------------------------------
package crypto_pkg;

    localparam int unsigned CRYPTO_WIDTH = 255;

    // 2^255 - 19 written as (2^255 - 1) - 18 so it fits in exactly 255 bits.
    localparam logic [CRYPTO_WIDTH-1:0] P25519 = {CRYPTO_WIDTH{1'b1}} - 255'd18;

    typedef enum logic [2:0] {
        AFF_IDLE  = 3'd0,
        AFF_SQR   = 3'd1,
        AFF_MUL_Z = 3'd2,
        AFF_MUL_X = 3'd3,
        AFF_DONE  = 3'd4,
        AFF_ERR   = 3'd5
    } aff_state_t;

    function automatic int unsigned popcount(input logic [511:0] v);
        int unsigned n;
        n = 0;
        for (int k = 0; k < 512; k++) begin
            if (v[k]) n++;
        end
        return n;
    endfunction

    // One start cycle plus 'width' bit cycles per multiply; width squarings,
    // one multiply by Z per set exponent bit, one final multiply by X, plus
    // the accept cycle and the DONE cycle.
    function automatic int unsigned aff_latency(input int unsigned width,
                                                input int unsigned pc);
        return 1 + (width + pc + 1) * (width + 1) + 1;
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// ---------------------------------------------------------------------------
// mod_mul_serial
// Interleaved bit-serial modular multiplier: result = a * b mod MODULUS.
// b is consumed MSB-first; each bit cycle doubles the accumulator and adds a
// when the current b bit is set, reducing after each step with at most one
// conditional subtraction (two per bit cycle in total).
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle pulse, latches a and b and clears the accumulator
//   a, b     : operands, must be < MODULUS
//   result   : product, valid in the cycle done is high
//   done     : one-cycle pulse, WIDTH cycles after start
// ---------------------------------------------------------------------------
module mod_mul_serial #(
    parameter int unsigned       WIDTH   = crypto_pkg::CRYPTO_WIDTH,
    parameter logic [WIDTH-1:0]  MODULUS = WIDTH'(crypto_pkg::P25519)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    // Two guard bits: doubling a value < p and adding a value < p both stay
    // below 2p < 2^(WIDTH+1).
    localparam int unsigned IW = WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [IW-1:0] MOD_EXT = {2'b00, MODULUS};

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    acc_q;

    logic [IW-1:0] dbl;
    logic [IW-1:0] dbl_red;
    logic [IW-1:0] sum;
    logic [IW-1:0] acc_d;

    assign dbl     = {acc_q[IW-2:0], 1'b0};
    assign dbl_red = (dbl >= MOD_EXT) ? dbl - MOD_EXT : dbl;
    // b_q is shifted left each bit cycle, so its MSB is the current bit.
    assign sum     = b_q[WIDTH-1] ? dbl_red + {2'b00, a_q} : dbl_red;
    assign acc_d   = (sum >= MOD_EXT) ? sum - MOD_EXT : sum;

    // The final bit's result is presented combinationally so the caller can
    // capture it on the same edge that retires the multiply.
    assign result = acc_d[WIDTH-1:0];
    assign done   = busy_q && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(WIDTH);
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
        end else if (busy_q) begin
            acc_q <= acc_d;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/proj_to_affine.sv
// ---------------------------------------------------------------------------
// proj_to_affine
// Converts a projective coordinate pair to affine: aff_data_out = X * Z^-1
// mod MODULUS, with Z^-1 = Z^(MODULUS-2) by left-to-right square-and-multiply
// over all WIDTH exponent bits, followed by one multiply by X. All multiplies
// share one mod_mul_serial instance. Latency is fixed per configuration.
//
// Handshake: a job is accepted on a rising edge where aff_valid && aff_ready.
// aff_ready is high only while idle; aff_valid while aff_ready is low is
// ignored (no queueing). Results come back as a one-cycle aff_data_valid
// pulse (or aff_error pulse); there is no output backpressure.
//
// Ports:
//   aff_clk, aff_reset        : clock, synchronous active-high reset
//   aff_valid, aff_ready      : request handshake
//   aff_x_in, aff_z_in        : projective X and Z, both < MODULUS
//   aff_data_out              : affine result, held until next result/error
//   aff_data_valid, aff_error : one-cycle completion / zero-denominator pulses
//   aff_dbg_state             : current controller state (observation only)
//
// Build option: define AFF_ZERO_CHECK_EN to reject Z == 0 in the accept cycle
// with an aff_error pulse. Without it aff_error is tied low and Z == 0 runs
// the full exponentiation, producing 0.
// ---------------------------------------------------------------------------
module proj_to_affine
    import crypto_pkg::*;
#(
    parameter int unsigned      WIDTH   = CRYPTO_WIDTH,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(P25519)
) (
    input  logic             aff_clk,
    input  logic             aff_reset,
    input  logic             aff_valid,
    input  logic [WIDTH-1:0] aff_x_in,
    input  logic [WIDTH-1:0] aff_z_in,
    output logic             aff_ready,
    output logic [WIDTH-1:0] aff_data_out,
    output logic             aff_data_valid,
    output logic             aff_error,
    output aff_state_t       aff_dbg_state
);

    localparam logic [WIDTH-1:0] EXP  = MODULUS - WIDTH'(2);
    localparam int unsigned      IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    aff_state_t       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             start_q, start_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             err_d;

    logic             accept;
    logic             mul_done;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_result;

    assign accept = aff_valid && ready_q;

    // The accumulator is always the a operand; b selects what it is
    // multiplied by in the current step.
    always_comb begin
        case (state_q)
            AFF_MUL_Z: mul_b = z_q;
            AFF_MUL_X: mul_b = x_q;
            default:   mul_b = acc_q;
        endcase
    end

    mod_mul_serial #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_mul (
        .clk    (aff_clk),
        .rst    (aff_reset),
        .start  (start_q),
        .a      (acc_q),
        .b      (mul_b),
        .result (mul_result),
        .done   (mul_done)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        z_d      = z_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            AFF_IDLE: begin
                if (accept) begin
                    x_d     = aff_x_in;
                    z_d     = aff_z_in;
                    acc_d   = WIDTH'(1);
                    idx_d   = IDXW'(WIDTH - 1);
                    state_d = AFF_SQR;
`ifdef AFF_ZERO_CHECK_EN
                    // Pulse the error in the ERR cycle itself, so it is
                    // registered here on the accept edge.
                    if (aff_z_in == '0) begin
                        state_d = AFF_ERR;
                        err_d   = 1'b1;
                        dout_d  = '0;
                    end
`endif
                end
            end
            AFF_SQR: begin
                if (mul_done) begin
                    acc_d = mul_result;
                    if (EXP[idx_q]) begin
                        state_d = AFF_MUL_Z;
                    end else if (idx_q == '0) begin
                        state_d = AFF_MUL_X;
                    end else begin
                        idx_d = idx_q - IDXW'(1);
                    end
                end
            end
            AFF_MUL_Z: begin
                if (mul_done) begin
                    acc_d = mul_result;
                    if (idx_q == '0) begin
                        state_d = AFF_MUL_X;
                    end else begin
                        idx_d   = idx_q - IDXW'(1);
                        state_d = AFF_SQR;
                    end
                end
            end
            AFF_MUL_X: begin
                if (mul_done) begin
                    acc_d   = mul_result;
                    state_d = AFF_DONE;
                end
            end
            AFF_DONE: begin
                dout_d   = acc_q;
                dvalid_d = 1'b1;
                state_d  = AFF_IDLE;
            end
            default: begin
                // AFF_ERR (only reachable with the zero check) and any
                // unused encoding return to idle.
                state_d = AFF_IDLE;
            end
        endcase

        // Kick the multiplier on the first cycle of every multiply state,
        // including SQR -> SQR transitions.
        start_d = ((state_d == AFF_SQR) || (state_d == AFF_MUL_Z) ||
                   (state_d == AFF_MUL_X)) &&
                  ((state_q == AFF_IDLE) || mul_done);

        // Ready stays low through the valid-pulse cycle after DONE, but
        // comes back right after the ERR cycle.
        ready_d = (state_d == AFF_IDLE) && (state_q != AFF_DONE);
    end

    always_ff @(posedge aff_clk) begin
        if (aff_reset) begin
            state_q  <= AFF_IDLE;
            x_q      <= '0;
            z_q      <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            start_q  <= 1'b0;
            ready_q  <= 1'b1;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            z_q      <= z_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            start_q  <= start_d;
            ready_q  <= ready_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

`ifdef AFF_ZERO_CHECK_EN
    logic err_q;

    always_ff @(posedge aff_clk) begin
        if (aff_reset) err_q <= 1'b0;
        else           err_q <= err_d;
    end

    assign aff_error = err_q;
`else
    assign aff_error = 1'b0;
`endif

    assign aff_ready      = ready_q;
    assign aff_data_out   = dout_q;
    assign aff_data_valid = dvalid_q;
    assign aff_dbg_state  = state_q;

endmodule

// File: doc/proj_to_affine.md
# proj_to_affine

Parametrised projective-to-affine converter for the crypto pipeline. It computes X·Z⁻¹ mod MODULUS, taking the inverse by Fermat exponentiation (Z^(MODULUS−2)) and then applying one final multiply. It replaces the separate inverse → 512-bit multiply → serial-modulo chain behind the Montgomery ladder with one handshaked, width-generic block. It adds backpressure, deterministic latency and optional zero-denominator detection.

## Interface
- WIDTH, 255, operand/result width in bits.
- MODULUS, 2^255−19, odd prime modulus. Must satisfy MODULUS < 2^WIDTH.
- aff_clk  in  1  sole clock; all logic on rising edge.
- aff_reset  in  1  synchronous, active-high reset.
- aff_valid  in  1  job request; accepted when aff_valid && aff_ready.
- aff_x_in  in  WIDTH  projective X. Must be < MODULUS.
- aff_z_in  in  WIDTH  projective Z. Must be < MODULUS.
- aff_ready  out  1  block idle, can accept a job. Reset value 1.
- aff_data_out  out  WIDTH  affine result; holds until the next result or error. Reset value 0.
- aff_data_valid  out  1  one-cycle pulse, result valid. Reset value 0.
- aff_error  out  1  one-cycle pulse, Z == 0. Reset value 0.

## Operation
- States: IDLE, SQR, MUL_Z, MUL_X, DONE, ERR.
- IDLE:
  - aff_ready = 1.
  - On accept, register X and Z, set acc = 1 and bit index i = WIDTH−1, then go to SQR.
  - Under AFF_ZERO_CHECK_EN, if Z == 0, go to ERR instead.
- Exponent E = MODULUS−2 is an elaboration-time constant. Scan it MSB-first over all WIDTH bits; leading zeros are still squared.
- SQR: acc ← acc·acc. If E[i] = 1, go to MUL_Z. Otherwise decrement i, or go to MUL_X if i == 0.
- MUL_Z: acc ← acc·Z. Then decrement i and go to SQR, or go to MUL_X if i == 0.
- MUL_X: acc ← acc·X, then go to DONE.
- DONE: aff_data_out ← acc, aff_data_valid = 1, go to IDLE.
- ERR: aff_data_out ← 0, aff_error = 1, go to IDLE.
- Every multiply is done by the interleaved bit-serial modular multiplier sub-module:
  - Processes b MSB-first: acc2 ← 2·acc2 mod p, then, if b bit set, acc2 ← acc2 + a mod p.
  - Each step uses at most two conditional subtractions of MODULUS.
  - Internal width is WIDTH+2 bits, so no intermediate ever exceeds 2^(WIDTH+1).
- Operands ≥ MODULUS give an undefined result; they are not checked.
- aff_valid while aff_ready = 0 is ignored; no queueing.
- aff_reset at any cycle, including mid-multiply:
  - Abort the job, return to IDLE, drive all outputs to reset values from the next cycle.
  - No valid or error pulse is issued for the aborted job.

## Timing
- Each multiply costs WIDTH+1 cycles: one start cycle plus WIDTH bit cycles. The sub-module's done pulses WIDTH cycles after its start.
- Latency from the accept cycle to the aff_data_valid cycle:
  - T = 1 + (WIDTH + popcount(E) + 1)·(WIDTH+1) + 1.
  - Fixed per configuration and independent of data.
- aff_ready falls in the cycle after accept and stays low through the valid/error cycle. It rises the following cycle. Minimum job spacing is therefore T+1 cycles.
- Under AFF_ZERO_CHECK_EN, aff_error pulses 1 cycle after accept (ERR state). aff_ready returns the cycle after that.
- aff_data_valid and aff_error are never high together.

## Configuration
- AFF_ZERO_CHECK_EN defined:
  - An IDLE comparator checks Z == 0.
  - The ERR path is active and gives a short-latency error.
- AFF_ZERO_CHECK_EN undefined:
  - No comparator and no ERR state; aff_error is tied 0.
  - Z = 0 runs the full exponentiation; 0^E = 0, so aff_data_valid pulses at T with aff_data_out = 0.

## Structure
- Shared package crypto_pkg holds:
  - CRYPTO_WIDTH = 255 and P25519 = 2^255−19 constants.
  - The aff_state_t state enum.
  - A popcount constant function for the latency formula, usable by bench and RTL.
- One sub-module: mod_mul_serial.
  - Parameters WIDTH, MODULUS.
  - Ports: start, a, b, result, done.
  - Reused later by the ladder rework.
- Top FSM, exponent index counter and operand registers stay in proj_to_affine.

## Test plan
All cases use WIDTH=8, MODULUS=251, giving E=249, popcount 6, T=137.
- X=5, Z=1 → aff_data_out=5; aff_data_valid exactly 137 cycles after accept.
- X=1, Z=2 → 126. X=3, Z=2 → 127. X=250, Z=250 → 1. Run back-to-back, asserting aff_valid continuously; each accept is spaced 138 cycles apart.
- Z=0, X=7:
  - With AFF_ZERO_CHECK_EN → aff_error pulse 1 cycle after accept, aff_data_out=0, no aff_data_valid.
  - Without the macro → aff_data_valid at 137 with 0.
- aff_reset asserted 50 cycles into a job (X=3, Z=2) → next cycle aff_ready=1, outputs 0, no pulse. A new job X=5, Z=1 then returns 5 at 137.
- aff_valid toggled while busy with differing X/Z → ignored; the in-flight result is unchanged and the ignored requests are never processed.
- WIDTH=255, MODULUS=2^255−19, X=9, Z=1 → 9. X=1, Z=2 → (p+1)/2. Latency matches the T formula.
